score_digit_sequencer: RTL and testbench
========================================

SCORE_DIGIT_SEQUENCER -- requirements
Module: score_digit_sequencer

Interface
REQ-001 Parameter DWELL_CYCLES, default 500000: clock cycles each digit is shown.
REQ-002 Parameter BLANK_CYCLES, default 100000: clock cycles of blank display between digits and after each full pass.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge system clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 score  in  8  binary game score, unsigned 0..255.
REQ-007 game_end  in  1  level; high while the game-over phase lasts.
REQ-008 seg  out  7  active-low segment drive, bit0=a .. bit6=g.
REQ-009 dp  out  1  active-low decimal point; marks a new best score.
REQ-010 busy  out  1  high while BCD conversion runs.
REQ-011 best  out  8  highest score captured since reset.
REQ-012 new_best  out  1  high while the displayed score set a new best.

Function
REQ-013 A 0->1 transition of game_end (registered edge detect) SHALL capture score in that cycle and enter CONVERT.
REQ-014 The FSM states SHALL be IDLE, CONVERT, SHOW, BLANK.
REQ-015 CONVERT: iterative shift-add-3 double-dabble, one bit per cycle, 8 cycles; busy high for exactly those 8 cycles; 12-bit BCD result (hundreds, tens, ones).
REQ-016 On the capture cycle: if score > best, then best <= score and new_best <= 1; otherwise new_best <= 0; a tie SHALL NOT update best or set new_best.
REQ-017 After CONVERT, the FSM SHALL enter SHOW at the first displayed digit.
REQ-018 Digit order: hundreds, tens, ones.
REQ-019 Leading-zero suppression: skip hundreds if it is 0; skip tens if hundreds and tens are both 0; ones always shown.
REQ-020 SHOW SHALL last DWELL_CYCLES; it SHALL then go to BLANK for BLANK_CYCLES; then to SHOW at the next digit; after ones, to SHOW at the first digit again (wrap).
REQ-021 In SHOW, seg SHALL carry the font code for the current digit.
REQ-022 In SHOW, dp SHALL be 0 only when the ones digit is shown and new_best=1; otherwise dp=1.
REQ-023 In IDLE, CONVERT and BLANK, seg SHALL be 7'h7F and dp SHALL be 1.
REQ-024 game_end low in any non-IDLE state SHALL force IDLE on the next cycle.
REQ-025 Entry to IDLE SHALL clear new_best and counters; best SHALL be kept.
REQ-026 A rising edge of game_end SHALL restart capture from any state.
REQ-027 score changes after the capture cycle SHALL NOT affect the displayed value.
REQ-028 Dwell and blank counters SHALL be wide enough for max(DWELL_CYCLES, BLANK_CYCLES) with no wrap.

Reset
REQ-029 While rst=1, outputs SHALL be: state IDLE, seg 7'h7F, dp 1, busy 0, best 0, new_best 0.
REQ-030 While rst=1, all counters, BCD registers and the edge-detect register SHALL be 0.
REQ-031 If reset is asserted mid-conversion or mid-display, the block SHALL abandon the operation with no partial output.
REQ-032 The first cycle after rst deasserts SHALL detect a rising edge if game_end is already high.

Structure
REQ-033 A shared package score_disp_pkg SHALL hold the state enum, SEG_BLANK (7'h7F) and the 0-9 active-low font table.
REQ-034 Font table values: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
REQ-035 The conversion SHALL be one sub-module bin2bcd_seq: start/done handshake, 8-bit in, 12-bit out.

Verification (bench: DWELL_CYCLES=4, BLANK_CYCLES=2)
REQ-036 Reset, then score=0 with game_end rising -> busy for 8 cycles; seg shows only 0 (7'h40) with dp=1; best stays 0; new_best=0.
REQ-037 Score 255 -> 2,5,5 shown; sequence 24,blank,12,blank,12(dp=0),blank; then wrap; best=255.
REQ-038 Score 7 after a 255 game -> only 7 (7'h78) shown; dp=1; new_best=0; best stays 255.
REQ-039 Score 40 then ties at 40 -> first game new_best=1; tie game new_best=0; display 4,0.
REQ-040 game_end falls mid-SHOW -> IDLE next cycle; seg=7F; new_best=0.
REQ-041 rst pulsed mid-CONVERT -> all outputs at reset values; best=0.

Source files
------------

// File: rtl/score_disp_pkg.sv
// Shared display types: FSM states, blank code, active-low 0-9 font and BCD helpers.
// No latency or backpressure of its own; pure declarations and functions.
package score_disp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SHOW    = 2'd2,
        BLANK   = 2'd3
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low, bit0 = segment a .. bit6 = segment g.
    localparam logic [6:0] FONT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    localparam logic [1:0] IDX_HUND = 2'd0;
    localparam logic [1:0] IDX_TENS = 2'd1;
    localparam logic [1:0] IDX_ONES = 2'd2;

    function automatic logic [6:0] seg_font(input logic [3:0] d);
        if (d > 4'd9) begin
            return SEG_BLANK;
        end
        return FONT[d];
    endfunction

    // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift.
    function automatic logic [11:0] dd_adjust(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] digit_at(input logic [11:0] bcd, input logic [1:0] idx);
        case (idx)
            IDX_HUND: return bcd[11:8];
            IDX_TENS: return bcd[7:4];
            default:  return bcd[3:0];
        endcase
    endfunction

    // Leading-zero suppression picks where each display pass begins.
    function automatic logic [1:0] first_idx(input logic [11:0] bcd);
        if (bcd[11:8] != 4'd0) begin
            return IDX_HUND;
        end
        if (bcd[7:4] != 4'd0) begin
            return IDX_TENS;
        end
        return IDX_ONES;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter, one bit per cycle.
// Latency: busy for 8 cycles after start, done pulses the cycle after; no backpressure, abort drops the job.
module bin2bcd_seq
    import score_disp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    logic [7:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            bin_d  = bin;
            bcd_d  = 12'd0;
            cnt_d  = 3'd0;
            busy_d = 1'b1;
        end else if (abort) begin
            busy_d = 1'b0;
            cnt_d  = 3'd0;
        end else if (busy_q) begin
            bcd_d = {dd_adjust(bcd_q) [10:0], bin_q[7]};
            bin_d = {bin_q[6:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= 8'd0;
            bcd_q  <= 12'd0;
            cnt_q  <= 3'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/score_digit_sequencer.sv
// Captures the score on a game_end rise, converts it to BCD and cycles the digits on one 7-seg display.
// Latency: first digit 9 cycles after the capture edge; no backpressure, game_end low returns to IDLE.
module score_digit_sequencer
    import score_disp_pkg::*;
#(
    parameter int DWELL_CYCLES = 500000,
    parameter int BLANK_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] score,
    input  logic       game_end,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy,
    output logic [7:0] best,
    output logic       new_best
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [7:0]       best_q, best_d;
    logic             nb_q, nb_d;
    logic             ge_q;

    logic        rise;
    logic        go_idle;
    logic        conv_done;
    logic [11:0] bcd;
    logic [1:0]  nxt_idx;

    assign rise    = game_end & ~ge_q;
    assign go_idle = ~rise & ~game_end & (state_q != IDLE);
    assign nxt_idx = (idx_q == IDX_ONES) ? first_idx(bcd) : idx_q + 2'd1;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (rise),
        .abort (go_idle),
        .bin   (score),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (bcd)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        seg_d   = seg_q;
        dp_d    = 1'b1;
        best_d  = best_q;
        nb_d    = nb_q;
        if (rise) begin
            state_d = CONVERT;
            idx_d   = IDX_HUND;
            cnt_d   = '0;
            seg_d   = SEG_BLANK;
            // A tie is not a new best.
            if (score > best_q) begin
                best_d = score;
                nb_d   = 1'b1;
            end else begin
                nb_d   = 1'b0;
            end
        end else if (go_idle) begin
            state_d = IDLE;
            idx_d   = IDX_HUND;
            cnt_d   = '0;
            seg_d   = SEG_BLANK;
            nb_d    = 1'b0;
        end else begin
            case (state_q)
                CONVERT: begin
                    if (conv_done) begin
                        state_d = SHOW;
                        idx_d   = first_idx(bcd);
                        cnt_d   = '0;
                        seg_d   = seg_font(digit_at(bcd, first_idx(bcd)));
                        dp_d    = ~((first_idx(bcd) == IDX_ONES) & nb_q);
                    end
                end
                SHOW: begin
                    if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        seg_d   = SEG_BLANK;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        dp_d    = ~((idx_q == IDX_ONES) & nb_q);
                    end
                end
                BLANK: begin
                    if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                        state_d = SHOW;
                        idx_d   = nxt_idx;
                        cnt_d   = '0;
                        seg_d   = seg_font(digit_at(bcd, nxt_idx));
                        dp_d    = ~((nxt_idx == IDX_ONES) & nb_q);
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    seg_d = SEG_BLANK;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= IDX_HUND;
            cnt_q   <= '0;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            best_q  <= 8'd0;
            nb_q    <= 1'b0;
            ge_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            best_q  <= best_d;
            nb_q    <= nb_d;
            ge_q    <= game_end;
        end
    end

    assign seg      = seg_q;
    assign dp       = dp_q;
    assign best     = best_q;
    assign new_best = nb_q;

endmodule

// File: tb/tb_score_digit_sequencer.sv
// Directed bench: expected display runs (segment code, dp, length) are queued per game and
// popped as the DUT completes each run of constant output.
module tb_score_digit_sequencer;

    localparam int DW = 4;
    localparam int BL = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       game_end;
    logic [7:0] score;
    logic [6:0] seg;
    logic       dp;
    logic       busy;
    logic [7:0] best;
    logic       new_best;

    always #5 clk = ~clk;

    score_digit_sequencer #(
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .score    (score),
        .game_end (game_end),
        .seg      (seg),
        .dp       (dp),
        .busy     (busy),
        .best     (best),
        .new_best (new_best)
    );

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        int         len;
    } run_t;

    run_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_best;
    logic       model_nb;
    int         busy_seen;
    logic [6:0] font [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_run(input logic [6:0] s, input logic d, input int l);
        run_t r;
        r.seg = s;
        r.dp  = d;
        r.len = l;
        sb.push_back(r);
    endtask

    // Queues the expected run sequence for one game; returns samples needed to close the last run.
    task automatic push_game(input logic [7:0] s, input int passes, output int samples);
        int h, t, o;
        int digs[$];
        h = int'(s) / 100;
        t = (int'(s) / 10) % 10;
        o = int'(s) % 10;
        model_nb = (s > model_best);
        if (model_nb) model_best = s;
        if (h != 0) digs.push_back(h);
        if (h != 0 || t != 0) digs.push_back(t);
        digs.push_back(o);
        push_run(7'h7F, 1'b1, 9);
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < digs.size(); i++) begin
                push_run(font[digs[i][3:0]], (i == digs.size() - 1) ? ~model_nb : 1'b1, DW);
                push_run(7'h7F, 1'b1, BL);
            end
        end
        samples = 9 + passes * digs.size() * (DW + BL) + 1;
    endtask

    task automatic watch(input int n);
        logic [6:0] ps;
        logic       pd;
        int         len;
        run_t       e;
        len       = 0;
        ps        = 7'h7F;
        pd        = 1'b1;
        busy_seen = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) score = 8'($urandom);
            if (busy) busy_seen++;
            if (len > 0 && seg === ps && dp === pd) begin
                len++;
            end else begin
                if (len > 0 && sb.size() > 0) begin
                    e = sb.pop_front();
                    check("run_seg", 32'(ps), 32'(e.seg));
                    check("run_dp", 32'(pd), 32'(e.dp));
                    check("run_len", len, e.len);
                end
                ps  = seg;
                pd  = dp;
                len = 1;
            end
        end
        check("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    task automatic start_game(input logic [7:0] s);
        @(negedge clk);
        game_end = 1'b0;
        @(negedge clk);
        score    = s;
        game_end = 1'b1;
    endtask

    task automatic play(input logic [7:0] s, input int passes);
        int n;
        start_game(s);
        push_game(s, passes, n);
        watch(n);
        check("busy_cycles", busy_seen, 8);
        check("best", 32'(best), 32'(model_best));
        check("new_best", 32'(new_best), 32'(model_nb));
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        game_end   = 1'b0;
        score      = 8'd0;
        model_best = 8'd0;
        model_nb   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_best", 32'(best), 32'd0);
        check("rst_new_best", 32'(new_best), 32'd0);
        rst = 1'b0;

        play(8'd0, 2);
        play(8'd40, 1);
        play(8'd40, 1);
        play(8'd255, 2);

        // Third pass has just begun on the hundreds digit; drop game_end mid-SHOW.
        check("pre_fall_seg", 32'(seg), 32'h24);
        game_end = 1'b0;
        @(negedge clk);
        check("fall_seg", 32'(seg), 32'h7F);
        check("fall_dp", 32'(dp), 32'd1);
        check("fall_new_best", 32'(new_best), 32'd0);
        check("fall_busy", 32'(busy), 32'd0);

        play(8'd7, 2);

        start_game(8'd200);
        repeat (3) @(negedge clk);
        check("mid_conv_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_seg", 32'(seg), 32'h7F);
        check("arst_dp", 32'(dp), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_best", 32'(best), 32'd0);
        check("arst_new_best", 32'(new_best), 32'd0);
        model_best = 8'd0;
        @(negedge clk);
        score = 8'd100;
        rst   = 1'b0;
        push_game(8'd100, 1, n);
        watch(n);
        check("post_rst_busy_cycles", busy_seen, 8);
        check("post_rst_best", 32'(best), 32'd100);
        check("post_rst_new_best", 32'(new_best), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
